uart_rx_ctrl: RTL and testbench

Receive-side frame controller for the UART RX path. It detects and validates the start bit, majority-samples each bit at the oversampled centre, deserializes the 8-bit payload LSB first, and sequences the external parity checker by pulsing its enable and capturing its error. It also checks the stop bit and reports a received byte, or a parity/framing error, to the RX FIFO/sync stage once per frame.

---
 rtl/uart_rx_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
//
// Receive-side frame controller for the UART RX path. Validates the start
// bit, majority-votes three oversampled points around each bit centre,
// shifts the 8-bit payload in LSB first, sequences the external parity
// checker, checks the stop bit, and reports one result pulse per frame.
//
// Ports:
//   CLK           rising-edge clock for all state
//   RST           asynchronous, active-low reset
//   RX_IN         synchronised serial line, idle high
//   Prescale      oversampling ratio (values below 8 are treated as 8)
//   PAR_EN        frame carries a parity bit
//   par_err       combinational error from the parity checker
//   sampled_bit   majority-voted value of the most recent bit
//   P_DATA        last deserialised byte
//   par_chk_en    one-cycle enable to the parity checker
//   Data_Valid    one-cycle pulse, good frame
//   Parity_Error  one-cycle pulse, parity check failed
//   Stop_Error    one-cycle pulse, stop bit sampled low
//   busy          high whenever a frame is in progress
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RX_IN,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    input  logic                      PAR_EN,
    input  logic                      par_err,
    output logic                      sampled_bit,
    output logic [7:0]                P_DATA,
    output logic                      par_chk_en,
    output logic                      Data_Valid,
    output logic                      Parity_Error,
    output logic                      Stop_Error,
    output logic                      busy
);

    localparam int W = PRESCALE_WIDTH;
    localparam logic [W-1:0] P_MIN = W'(8);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e       state_q,       state_d;
    logic [W-1:0] edge_cnt_q,    edge_cnt_d;
    logic [2:0]   bit_cnt_q,     bit_cnt_d;
    logic [W-1:0] p_q,           p_d;          // latched, clamped prescale
    logic         par_en_q,      par_en_d;     // latched parity enable
    logic [2:0]   sample_q,      sample_d;     // the three centre samples
    logic         sampled_bit_q, sampled_bit_d;
    logic [7:0]   p_data_q,      p_data_d;
    logic         par_flag_q,    par_flag_d;
    logic         stop_flag_q,   stop_flag_d;

    // Edge positions within a bit, all derived from the latched ratio.
    logic [W-1:0] half;
    logic [W-1:0] pos_s0, pos_s1, pos_s2, pos_vote, pos_check, pos_last;
    logic         edge_last;
    logic         majority;

    logic         par_chk_en_c;
    logic         data_valid_c;
    logic         parity_error_c;
    logic         stop_error_c;

    always_comb begin
        half      = p_q >> 1;
        pos_s0    = half - W'(2);
        pos_s1    = half - W'(1);
        pos_s2    = half;
        pos_vote  = half + W'(1);
        pos_check = half + W'(2);
        pos_last  = p_q - W'(1);
    end

    assign edge_last = (edge_cnt_q == pos_last);
    assign majority  = (sample_q[0] & sample_q[1]) |
                       (sample_q[0] & sample_q[2]) |
                       (sample_q[1] & sample_q[2]);

    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d        = state_q;
        edge_cnt_d     = edge_cnt_q;
        bit_cnt_d      = bit_cnt_q;
        p_d            = p_q;
        par_en_d       = par_en_q;
        sample_d       = sample_q;
        sampled_bit_d  = sampled_bit_q;
        p_data_d       = p_data_q;
        par_flag_d     = par_flag_q;
        stop_flag_d    = stop_flag_q;
        par_chk_en_c   = 1'b0;
        data_valid_c   = 1'b0;
        parity_error_c = 1'b0;
        stop_error_c   = 1'b0;

        // Bit timing and centre sampling are common to every active state.
        if (state_q != S_IDLE) begin
            edge_cnt_d = edge_last ? '0 : edge_cnt_q + W'(1);
            if (edge_cnt_q == pos_s0) sample_d[0] = RX_IN;
            if (edge_cnt_q == pos_s1) sample_d[1] = RX_IN;
            if (edge_cnt_q == pos_s2) sample_d[2] = RX_IN;
            if (edge_cnt_q == pos_vote) sampled_bit_d = majority;
        end

        case (state_q)
            S_IDLE: begin
                edge_cnt_d = '0;
                bit_cnt_d  = '0;
                if (!RX_IN) begin
                    // Frame configuration is frozen here for the whole frame.
                    state_d     = S_START;
                    p_d         = (Prescale < P_MIN) ? P_MIN : Prescale;
                    par_en_d    = PAR_EN;
                    par_flag_d  = 1'b0;
                    stop_flag_d = 1'b0;
                end
            end

            S_START: begin
                if (edge_last) begin
                    // A start bit that votes high was a glitch: drop silently.
                    if (!sampled_bit_q) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end

            S_DATA: begin
                if (edge_cnt_q == pos_vote) p_data_d = {majority, p_data_q[7:1]};
                if (edge_last) begin
                    if (bit_cnt_q != 3'd7) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else begin
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end
                end
            end

            S_PARITY: begin
                // The vote lands at pos_vote, so the checker sees a settled bit.
                if (edge_cnt_q == pos_check) begin
                    par_chk_en_c = 1'b1;
                    par_flag_d   = par_err;
                end
                if (edge_last) state_d = S_STOP;
            end

            S_STOP: begin
                if (edge_cnt_q == pos_check) stop_flag_d = ~sampled_bit_q;
                if (edge_last) begin
                    data_valid_c   = ~par_flag_q & ~stop_flag_q;
                    parity_error_c = par_flag_q;
                    stop_error_c   = stop_flag_q;
                    state_d        = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= S_IDLE;
            edge_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            p_q           <= P_MIN;
            par_en_q      <= 1'b0;
            sample_q      <= 3'b111;
            sampled_bit_q <= 1'b1;
            p_data_q      <= 8'h00;
            par_flag_q    <= 1'b0;
            stop_flag_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q       <= state_d;
            edge_cnt_q    <= edge_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            p_q           <= p_d;
            par_en_q      <= par_en_d;
            sample_q      <= sample_d;
            sampled_bit_q <= sampled_bit_d;
            p_data_q      <= p_data_d;
            par_flag_q    <= par_flag_d;
            stop_flag_q   <= stop_flag_d;
        end
    end

    // Pulses decode registered state only, so a reset clears them at once.
    assign sampled_bit  = sampled_bit_q;
    assign P_DATA       = p_data_q;
    assign par_chk_en   = par_chk_en_c;
    assign Data_Valid   = data_valid_c;
    assign Parity_Error = parity_error_c;
    assign Stop_Error   = stop_error_c;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
//
// Drives serial frames into uart_rx_ctrl cycle by cycle and checks busy, the
// result pulses, par_chk_en, P_DATA and sampled_bit against timings derived
// arithmetically from the frame rules (bit k of a frame occupies cycles
// k*P .. k*P+P-1, result pulse at F-1, parity enable at 9*P+H+2).
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic          RX_IN;
    logic [PW-1:0] Prescale;
    logic          PAR_EN;
    logic          par_err;
    logic          sampled_bit;
    logic [7:0]    P_DATA;
    logic          par_chk_en;
    logic          Data_Valid;
    logic          Parity_Error;
    logic          Stop_Error;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc_abs = 0;
    logic [7:0] prev_byte;

    uart_rx_ctrl #(.PRESCALE_WIDTH(PW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .par_err      (par_err),
        .sampled_bit  (sampled_bit),
        .P_DATA       (P_DATA),
        .par_chk_en   (par_chk_en),
        .Data_Valid   (Data_Valid),
        .Parity_Error (Parity_Error),
        .Stop_Error   (Stop_Error),
        .busy         (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc_abs <= cyc_abs + 1;

    // One frame. Cycle -1 is the IDLE cycle where the start bit first shows;
    // cycle 0 is the first START cycle. Line level for cycle c is bit (c+1)/P.
    task automatic run_frame(input int pres, input bit pen, input logic [7:0] data,
                             input bit par_ok, input bit stop_lvl, input bit short_start,
                             input int glitch_cyc, input int change_cyc, input int abort_cyc,
                             input string name, output int dv_at);
        int p, h, f, last_cyc, exp_pce, busy_bad, pulse_bad, first_b, first_p;
        bit par_bit, exp_good, aborted;
        bit levels[$];
        logic [3:0] got_v, exp_v, first_got, first_exp;
        logic [7:0] data_end;
        logic sb_end;
        logic [13:0] rst_got;

        p        = (pres < 8) ? 8 : pres;
        h        = p / 2;
        f        = (pen ? 11 : 10) * p;
        par_bit  = (^data) ^ !par_ok;   // even parity, deliberately wrong when !par_ok
        exp_good = stop_lvl && (!pen || par_ok);
        exp_pce  = (pen && !short_start) ? 9 * p + h + 2 : -100;
        last_cyc = short_start ? p : f - 1;
        busy_bad = 0; pulse_bad = 0; first_b = -9; first_p = -9;
        first_got = '0; first_exp = '0;
        data_end = '0; sb_end = 1'b0; aborted = 1'b0;
        dv_at = -1;

        levels.push_back(1'b0);
        for (int i = 0; i < 8; i++) levels.push_back(data[i]);
        if (pen) levels.push_back(par_bit);
        levels.push_back(stop_lvl);

        for (int c = -1; c <= last_cyc; c++) begin
            bit lvl;
            bit eb;
            @(posedge CLK); #1;
            if (c == -1) begin
                Prescale = PW'(pres);
                PAR_EN   = pen;
            end
            if (short_start) lvl = (c <= 0) ? 1'b0 : 1'b1;
            else if (c + 1 < f) lvl = levels[(c + 1) / p];
            else lvl = 1'b1;
            if (c == glitch_cyc) lvl = !lvl;
            RX_IN   = lvl;
            par_err = (c == exp_pce) ? ((^data) ^ par_bit) : 1'b0;
            if (c == change_cyc) begin
                Prescale = PW'($urandom_range(8, 32));
                PAR_EN   = !pen;
            end
            if (c == abort_cyc) begin
                RST = 1'b0;
                #1;
                rst_got = {busy, Data_Valid, Parity_Error, Stop_Error, par_chk_en, sampled_bit, P_DATA};
                total++;
                if (rst_got !== {5'b00000, 1'b1, 8'h00}) begin
                    bad++;
                    $display("FAIL %s reset_mid_frame: got=%b exp=%b", name, rst_got, {5'b00000, 1'b1, 8'h00});
                end
                aborted = 1'b1;
                break;
            end
            @(negedge CLK);
            eb = (c >= 0) && (c <= (short_start ? p - 1 : f - 1));
            if (busy !== eb) begin
                busy_bad++;
                if (first_b == -9) first_b = c;
            end
            got_v = {Data_Valid, Parity_Error, Stop_Error, par_chk_en};
            exp_v = {!short_start && c == f - 1 && exp_good,
                     !short_start && c == f - 1 && pen && !par_ok,
                     !short_start && c == f - 1 && !stop_lvl,
                     c == exp_pce};
            if (got_v !== exp_v) begin
                pulse_bad++;
                if (first_p == -9) begin
                    first_p = c; first_got = got_v; first_exp = exp_v;
                end
            end
            if (Data_Valid === 1'b1) dv_at = cyc_abs;
            if (c == (short_start ? last_cyc : p + h + 1)) begin
                total++;
                if (P_DATA !== prev_byte) begin
                    bad++;
                    $display("FAIL %s p_data_hold: got=%h exp=%h", name, P_DATA, prev_byte);
                end
            end
            if (c == last_cyc) begin
                data_end = P_DATA;
                sb_end   = sampled_bit;
            end
        end

        if (aborted) begin
            prev_byte = 8'h00;
        end else begin
            total++;
            if (busy_bad != 0) begin
                bad++;
                $display("FAIL %s busy: %0d bad cycles, first cycle %0d", name, busy_bad, first_b);
            end
            total++;
            if (pulse_bad != 0) begin
                bad++;
                $display("FAIL %s pulses{dv,pe,se,pce}: %0d bad cycles, cycle %0d got=%b exp=%b",
                         name, pulse_bad, first_p, first_got, first_exp);
            end
            if (!short_start) begin
                total++;
                if (data_end !== data) begin
                    bad++;
                    $display("FAIL %s p_data: got=%h exp=%h", name, data_end, data);
                end
                total++;
                if (sb_end !== stop_lvl) begin
                    bad++;
                    $display("FAIL %s sampled_bit_stop: got=%b exp=%b", name, sb_end, stop_lvl);
                end
                prev_byte = data;
            end
        end
    endtask

    // Idle line for n cycles; busy and every pulse must stay low.
    task automatic idle_check(input int n, input string name);
        int errs;
        errs = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            RX_IN   = 1'b1;
            par_err = 1'b0;
            @(negedge CLK);
            if ({busy, Data_Valid, Parity_Error, Stop_Error, par_chk_en} !== 5'b0) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL %s idle_quiet: %0d active cycles, exp 0", name, errs);
        end
    endtask

    task automatic test_reset();
        logic [13:0] got;
        RST = 1'b0; RX_IN = 1'b0; Prescale = PW'(8); PAR_EN = 1'b0; par_err = 1'b0;
        repeat (3) @(negedge CLK);
        got = {busy, Data_Valid, Parity_Error, Stop_Error, par_chk_en, sampled_bit, P_DATA};
        total++;
        if (got !== {5'b00000, 1'b1, 8'h00}) begin
            bad++;
            $display("FAIL reset_values: got=%b exp=%b", got, {5'b00000, 1'b1, 8'h00});
        end
        RX_IN = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        prev_byte = 8'h00;
        idle_check(4, "after_reset");
    endtask

    task automatic test_basic_no_parity();
        int dv;
        run_frame(8, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, -100, -100, -100, "p8_a5", dv);
        idle_check(3, "p8_a5");
    endtask

    task automatic test_parity_good();
        int dv;
        run_frame(16, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, -100, -100, -100, "p16_par_ok", dv);
        idle_check(3, "p16_par_ok");
    endtask

    task automatic test_parity_error();
        int dv;
        run_frame(8, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, -100, -100, -100, "p8_par_err", dv);
        idle_check(3, "p8_par_err");
    endtask

    task automatic test_start_glitch();
        int dv;
        run_frame(8, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, -100, -100, -100, "start_glitch", dv);
        idle_check(3, "start_glitch");
    endtask

    task automatic test_back_to_back();
        int dv0, dv1, dv2;
        run_frame(32, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, -100, -100, -100, "p32_stop_err", dv0);
        run_frame(32, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0, -100, -100, -100, "b2b_55", dv1);
        run_frame(32, 1'b0, 8'hAA, 1'b1, 1'b1, 1'b0, -100, -100, -100, "b2b_aa", dv2);
        total++;
        if (dv2 - dv1 !== 10 * 32 + 1) begin
            bad++;
            $display("FAIL b2b_spacing: got=%0d exp=%0d", dv2 - dv1, 10 * 32 + 1);
        end
        idle_check(3, "b2b");
    endtask

    task automatic test_reset_mid_frame();
        int dv;
        run_frame(8, 1'b0, 8'h5A, 1'b1, 1'b1, 1'b0, -100, -100, 40, "abort", dv);
        repeat (2) @(posedge CLK);
        #1 RX_IN = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        idle_check(6, "post_abort");
        run_frame(8, 1'b0, 8'h81, 1'b1, 1'b1, 1'b0, -100, -100, -100, "after_abort_81", dv);
        idle_check(3, "after_abort_81");
    endtask

    task automatic test_prescale_clamp();
        int dv;
        run_frame(3, 1'b1, 8'($urandom), 1'b1, 1'b1, 1'b0, -100, -100, -100, "clamp_p3", dv);
        idle_check(3, "clamp_p3");
    endtask

    task automatic test_config_change();
        int dv;
        run_frame(12, 1'b1, 8'($urandom), 1'b1, 1'b1, 1'b0, -100, 5, -100, "mid_change", dv);
        idle_check(3, "mid_change");
    endtask

    // Random frames with a one-cycle glitch on the middle sample of a data bit.
    task automatic test_random();
        int dv, p, k;
        for (int i = 0; i < 8; i++) begin
            p = $urandom_range(8, 32);
            k = $urandom_range(1, 8);
            run_frame(p, 1'($urandom_range(0, 1)), 8'($urandom),
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'b0,
                      k * p + p / 2 - 1, -100, -100, $sformatf("rand%0d_p%0d", i, p), dv);
            if ($urandom_range(0, 1) == 1) idle_check(2, "rand_gap");
        end
    endtask

    initial begin
        test_reset();
        test_basic_no_parity();
        test_parity_good();
        test_parity_error();
        test_start_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        test_prescale_clamp();
        test_config_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
